// File: rtl/pgm_sprite_scan.sv
// pgm_sprite_scan: per-line sprite attribute walker that queues descriptors of intersecting sprites.
// Latency: miss 2 cycles/entry, hit 6 cycles/entry; desc_valid rises the cycle after the FIFO write.
// Backpressure: a full descriptor FIFO with desc_ready low stalls the walk in PUSH until a slot frees.
//
// Ports: clk/reset (async, active-high); line_start/line_y start a scan; sprite_addr/sprite_dout
// read attribute RAM (data one cycle after address); desc_* is the valid/ready descriptor stream
// taken from the FIFO head; scan_busy/scan_done/overflow report walk status.
// Optional feature: define PGM_SPRITE_SCAN_FLIPY_EN to honour w1[15] (vertical flip) in desc_row.
module pgm_sprite_scan #(
    parameter int NUM_SPRITES  = 256,
    parameter int MAX_PER_LINE = 32,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [8:0]  line_y,
    output logic [9:0]  sprite_addr,
    input  logic [15:0] sprite_dout,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [10:0] desc_x,
    output logic [15:0] desc_code,
    output logic [4:0]  desc_pal,
    output logic [4:0]  desc_width,
    output logic [7:0]  desc_row,
    output logic        desc_flipx,
    output logic        scan_busy,
    output logic        scan_done,
    output logic        overflow
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_SPRITES - 1);
    localparam logic [8:0]  MAX_HITS  = 9'(MAX_PER_LINE);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [10:0] x;
        logic [15:0] code;
        logic [4:0]  pal;
        logic [4:0]  width;
        logic [7:0]  row;
        logic        flipx;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_Y, S_CHK_Y, S_RD_REST, S_PUSH, S_NEXT, S_DONE
    } state_t;

    state_t      state, state_n;
    logic [8:0]  line_q;
    logic [7:0]  idx;
    logic [8:0]  hits;
    logic        overflow_q;
    logic        sub;        // RD_REST phase: 0 = w0 on bus, 1 = w2 on bus
    logic [7:0]  dy_q;
    logic [10:0] x_q;
    logic        flipx_q;
    logic [15:0] code_q;

    logic [9:0]  dy_c;
    logic [10:0] span_c;
    logic        hit_c, last_c, busy_c, flush, push, pop, fifo_full, can_push;
    logic [7:0]  row_c;
    desc_t       desc_in, head;

    // Vertical distance wraps modulo 1024 so sprites straddling y=1023/0 still hit.
    assign dy_c   = {1'b0, line_q} - sprite_dout[9:0];
    assign span_c = {2'b00, ({1'b0, sprite_dout[14:10]} + 6'd1), 3'b000};
    assign hit_c  = ({1'b0, dy_c} < span_c);
    assign last_c = (idx == LAST_IDX);
    assign busy_c = (state != S_IDLE) && (state != S_DONE);
    assign flush  = line_start & busy_c;

    assign scan_busy = busy_c;
    assign scan_done = (state == S_DONE);
    assign overflow  = overflow_q;

`ifdef PGM_SPRITE_SCAN_FLIPY_EN
    logic [4:0] hgt_q;
    logic       flipy_q;
    logic [8:0] span_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hgt_q   <= '0;
            flipy_q <= 1'b0;
        end else if (!line_start && state == S_CHK_Y && hit_c) begin
            hgt_q   <= sprite_dout[14:10];
            flipy_q <= sprite_dout[15];
        end
    end

    assign span_q = {({1'b0, hgt_q} + 6'd1), 3'b000};
    assign row_c  = flipy_q ? 8'(span_q - 9'd1 - {1'b0, dy_q}) : dy_q;
`else
    assign row_c  = dy_q;
`endif

    // w3 is not latched: the address stays on word 3 through PUSH, so the RAM keeps presenting it.
    always_comb begin
        desc_in       = '0;
        desc_in.x     = x_q;
        desc_in.code  = code_q;
        desc_in.pal   = sprite_dout[15:11];
        desc_in.width = sprite_dout[10:6];
        desc_in.row   = row_c;
        desc_in.flipx = flipx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        sprite_addr = '0;
        push        = 1'b0;
        case (state)
            S_RD_Y: begin
                sprite_addr = {idx, 2'd1};
                state_n     = S_CHK_Y;
            end
            S_CHK_Y: begin
                if (hit_c) begin
                    sprite_addr = {idx, 2'd0};
                    state_n     = S_RD_REST;
                end else if (last_c) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_RD_Y;
                end
            end
            S_RD_REST: begin
                if (!sub) begin
                    sprite_addr = {idx, 2'd2};
                    state_n     = sprite_dout[14] ? S_DONE : S_RD_REST;
                end else begin
                    sprite_addr = {idx, 2'd3};
                    state_n     = S_PUSH;
                end
            end
            S_PUSH: begin
                sprite_addr = {idx, 2'd3};
                if (hits == MAX_HITS) begin
                    state_n = S_NEXT;
                end else if (can_push) begin
                    push    = 1'b1;
                    state_n = S_NEXT;
                end
            end
            S_NEXT:  state_n = last_c ? S_DONE : S_RD_Y;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // A new line strobe always wins, whatever the walk was doing.
        if (line_start) state_n = S_RD_Y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q     <= '0;
            idx        <= '0;
            hits       <= '0;
            overflow_q <= 1'b0;
            sub        <= 1'b0;
            dy_q       <= '0;
            x_q        <= '0;
            flipx_q    <= 1'b0;
            code_q     <= '0;
        end else if (line_start) begin
            line_q     <= line_y;
            idx        <= '0;
            hits       <= '0;
            overflow_q <= 1'b0;
            sub        <= 1'b0;
        end else begin
            case (state)
                S_CHK_Y: begin
                    if (hit_c) begin
                        dy_q <= dy_c[7:0];
                        sub  <= 1'b0;
                    end else if (!last_c) begin
                        idx <= idx + 8'd1;
                    end
                end
                S_RD_REST: begin
                    sub <= ~sub;
                    if (!sub) begin
                        x_q     <= sprite_dout[10:0];
                        flipx_q <= sprite_dout[15];
                    end else begin
                        code_q <= sprite_dout;
                    end
                end
                S_PUSH: begin
                    if (hits == MAX_HITS)  overflow_q <= 1'b1;
                    else if (can_push)     hits       <= hits + 9'd1;
                end
                S_NEXT: begin
                    if (!last_c) idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Descriptor FIFO: head is read straight from the register array, gated to zero when empty.
    desc_t         fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    assign fifo_full  = (count == FIFO_FULL);
    assign desc_valid = (count != '0);
    assign pop        = desc_valid & desc_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign can_push   = ~fifo_full | pop;

    always_ff @(posedge clk) begin
        if (push && !flush) fifo_mem[wr_ptr] <= desc_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head       = desc_valid ? fifo_mem[rd_ptr] : '0;
    assign desc_x     = head.x;
    assign desc_code  = head.code;
    assign desc_pal   = head.pal;
    assign desc_width = head.width;
    assign desc_row   = head.row;
    assign desc_flipx = head.flipx;
endmodule

// File: tb/tb_pgm_sprite_scan.sv
// Bench for pgm_sprite_scan: directed line scans against a behavioural attribute RAM,
// expected descriptors queued per scan and matched by an independent output monitor.
module tb_pgm_sprite_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [8:0]  line_y = '0;
    logic [9:0]  sprite_addr;
    logic [15:0] sprite_dout;
    logic        desc_valid;
    logic        desc_ready = 1'b0;
    logic [10:0] desc_x;
    logic [15:0] desc_code;
    logic [4:0]  desc_pal;
    logic [4:0]  desc_width;
    logic [7:0]  desc_row;
    logic        desc_flipx;
    logic        scan_busy, scan_done, overflow;

    logic [15:0] ram [1024];
    int          checks = 0;
    int          errors = 0;
    logic [45:0] exp_q [$];
    logic [45:0] act, held, want;
    logic        have_held = 1'b0;

    pgm_sprite_scan dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
        .sprite_addr(sprite_addr), .sprite_dout(sprite_dout),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_x(desc_x), .desc_code(desc_code), .desc_pal(desc_pal),
        .desc_width(desc_width), .desc_row(desc_row), .desc_flipx(desc_flipx),
        .scan_busy(scan_busy), .scan_done(scan_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sprite_dout <= ram[sprite_addr];

    assign act = {desc_x, desc_code, desc_pal, desc_width, desc_row, desc_flipx};

    function automatic logic [45:0] mk(input logic [10:0] x, input logic [15:0] code,
                                       input logic [4:0] pal, input logic [4:0] w,
                                       input logic [7:0] row, input logic fx);
        return {x, code, pal, w, row, fx};
    endfunction

    task automatic chk(input string name, input logic [45:0] got, input logic [45:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Monitor: every accepted descriptor is matched against the head of the expected queue,
    // and a descriptor held under backpressure must not change.
    always @(negedge clk) begin
        if (desc_valid && desc_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_desc got=%h want=none", act);
            end else begin
                want = exp_q.pop_front();
                if (act !== want) begin
                    errors++;
                    $display("FAIL desc_match got=%h want=%h", act, want);
                end
            end
        end
        if (have_held && desc_valid) begin
            checks++;
            if (act !== held) begin
                errors++;
                $display("FAIL desc_stable got=%h want=%h", act, held);
            end
        end
        have_held = desc_valid && !desc_ready;
        held      = act;
    end

    task automatic clear_ram();
        // Default entries sit at y=512: no line 0..511 is within their 8-line span.
        for (int i = 0; i < 256; i++) begin
            ram[i*4]   = 16'h0000;
            ram[i*4+1] = 16'h0200;
            ram[i*4+2] = 16'h0000;
            ram[i*4+3] = 16'h0000;
        end
    endtask

    task automatic set_ent(input int i, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
        ram[i*4]   = w0;
        ram[i*4+1] = w1;
        ram[i*4+2] = w2;
        ram[i*4+3] = w3;
    endtask

    task automatic start_line(input logic [8:0] y);
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y     = y;
        @(posedge clk); #1;
        line_start = 1'b0;
        chk("busy_after_start", scan_busy, 1);
        chk("overflow_cleared", overflow, 0);
    endtask

    task automatic wait_done(input int budget, input logic exp_ovf);
        int n;
        n = 0;
        while (scan_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("scan_done_seen", scan_done, 1);
        chk("busy_low_with_done", scan_busy, 0);
        chk("overflow_flag", overflow, exp_ovf);
        n = 0;
        while ((exp_q.size() != 0 || desc_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("fifo_empty_after", desc_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ram();
        repeat (3) @(negedge clk);
        chk("rst_addr", sprite_addr, 0);
        chk("rst_valid", desc_valid, 0);
        chk("rst_desc", act, 0);
        chk("rst_status", {scan_busy, scan_done, overflow}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Single hit: entry 5, y=100, 16 lines tall, line 110 -> row 10.
        set_ent(5, 16'h8123, 16'h0464, 16'h1234, 16'hA8C0);
        desc_ready = 1'b1;
        exp_q.push_back(mk(11'h123, 16'h1234, 5'h15, 5'd3, 8'd10, 1'b1));
        start_line(9'd110);
        wait_done(2000, 1'b0);

        // Wrap: y=1020, 8 lines; line 2 -> row 6, line 4 -> miss.
        clear_ram();
        set_ent(7, 16'h0040, 16'h03FC, 16'h0777, 16'h0000);
        exp_q.push_back(mk(11'h040, 16'h0777, 5'd0, 5'd0, 8'd6, 1'b0));
        start_line(9'd2);
        wait_done(2000, 1'b0);
        start_line(9'd4);
        wait_done(2000, 1'b0);

        // Overflow: 40 hits on line 50, only the first 32 come out.
        clear_ram();
        for (int i = 0; i < 40; i++) begin
            set_ent(i, 16'(i), 16'h0032, 16'h3000 + 16'(i), 16'h0000);
            if (i < 32) exp_q.push_back(mk(11'(i), 16'h3000 + 16'(i), 5'd0, 5'd0, 8'd0, 1'b0));
        end
        start_line(9'd50);
        wait_done(3000, 1'b1);

        // Backpressure: 10 hits, consumer stalled; 8 fill the FIFO and entry 18 waits in PUSH.
        clear_ram();
        desc_ready = 1'b0;
        for (int i = 10; i < 20; i++) begin
            set_ent(i, 16'h0000, 16'h00C8, 16'h0100 + 16'(i), 16'h0000);
            exp_q.push_back(mk(11'd0, 16'h0100 + 16'(i), 5'd0, 5'd0, 8'd0, 1'b0));
        end
        start_line(9'd200);
        repeat (300) @(negedge clk);
        chk("stall_busy", scan_busy, 1);
        chk("stall_valid", desc_valid, 1);
        chk("stall_head_code", desc_code, 16'h010A);
        chk("stall_addr", sprite_addr, 10'd75);
        @(posedge clk); #1 desc_ready = 1'b1;
        wait_done(3000, 1'b0);

        // Restart mid-scan: line 60 hits are flushed, only line 300's entry 30 survives.
        clear_ram();
        desc_ready = 1'b0;
        for (int i = 0; i < 20; i++) set_ent(i, 16'h0000, 16'h003C, 16'h0200 + 16'(i), 16'h0000);
        set_ent(30, 16'h0000, 16'h012C, 16'hBEEF, 16'h0000);
        start_line(9'd60);
        repeat (100) @(negedge clk);
        start_line(9'd300);
        chk("flush_valid_drop", desc_valid, 0);
        exp_q.push_back(mk(11'd0, 16'hBEEF, 5'd0, 5'd0, 8'd0, 1'b0));
        desc_ready = 1'b1;
        wait_done(2000, 1'b0);

        // Async reset while stalled in PUSH: outputs clear without a clock edge.
        desc_ready = 1'b0;
        start_line(9'd60);
        repeat (100) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("arst_valid", desc_valid, 0);
        chk("arst_desc", act, 0);
        chk("arst_status", {scan_busy, scan_done, overflow}, 0);
        chk("arst_addr", sprite_addr, 0);
        @(negedge clk) reset = 1'b0;

        // End-of-list on entry 2 stops the walk; entry 4 must never appear.
        clear_ram();
        desc_ready = 1'b1;
        set_ent(2, 16'h4000, 16'h0190, 16'h0222, 16'h0000);
        set_ent(4, 16'h0000, 16'h0190, 16'h0444, 16'h0000);
        start_line(9'd400);
        wait_done(100, 1'b0);

        // Vertical flip: 16-line sprite at y=0, line 3; plus a hit on the last entry.
        clear_ram();
        set_ent(3, 16'h0000, 16'h8400, 16'h0F0F, 16'h0000);
        set_ent(255, 16'h0001, 16'h0000, 16'h0FFF, 16'h0000);
`ifdef PGM_SPRITE_SCAN_FLIPY_EN
        exp_q.push_back(mk(11'd0, 16'h0F0F, 5'd0, 5'd0, 8'd12, 1'b0));
`else
        exp_q.push_back(mk(11'd0, 16'h0F0F, 5'd0, 5'd0, 8'd3, 1'b0));
`endif
        exp_q.push_back(mk(11'd1, 16'h0FFF, 5'd0, 5'd0, 8'd3, 1'b0));
        start_line(9'd3);
        wait_done(2000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
